dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: the pipeline memory stage (CPU) and an external master (EXT), which can be a loader, DMA or debug port.
- Sits between the memory stage and the DataMemory instance and drives DataMemory's memRead/memWrite/address/writeData.
- CPU has priority. EXT is protected from starvation by a bounded-wait counter. When a CPU access loses arbitration, the block raises a stall to the hazard unit.

Parameters:
- MAX_WAIT, 3, max consecutive cycles a valid EXT request can be blocked by the CPU before it is forcibly granted (0 = EXT wins whenever valid)
- WAIT_W, 4, width of wait counter; must hold MAX_WAIT
- CNT_W, 16, width of stall statistics counter

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- cpu_read  in  1  CPU load request (MemReadM)
- cpu_write  in  1  CPU store request (MemWriteM)
- cpu_addr  in  32  CPU address (ALUOutM)
- cpu_wdata  in  32  CPU store data (WriteDataM)
- cpu_rdata  out  32  load data to CPU, combinational from mem_rdata
- cpu_stall  out  1  CPU access not performed this cycle; freeze pipeline
- ext_valid  in  1  EXT request valid; held with its fields until ext_ready
- ext_we  in  1  1 = write, 0 = read
- ext_addr  in  32  EXT address
- ext_wdata  in  32  EXT write data
- ext_ready  out  1  EXT request accepted and performed this cycle
- ext_rvalid  out  1  EXT read data valid (one cycle after accept)
- ext_rdata  out  32  EXT read data, registered
- mem_read  out  1  to DataMemory memRead
- mem_write  out  1  to DataMemory memWrite
- mem_addr  out  32  to DataMemory address
- mem_wdata  out  32  to DataMemory writeData
- mem_rdata  in  32  from DataMemory readData (combinational read)
- stall_cnt  out  CNT_W  saturating count of cycles cpu_stall was high

Behaviour:
- cpu_req = cpu_read | cpu_write. If both are asserted, treat as a write: mem_read=0.
- State is wait_cnt (WAIT_W bits). Two logical states: CPU_PRI when wait_cnt < MAX_WAIT, FORCE when wait_cnt == MAX_WAIT.
- ext_grant (combinational) = ext_valid & (~cpu_req | FORCE).
- ext_ready = ext_grant.
- cpu_stall = cpu_req & ext_grant.
- Memory mux when ext_grant:
  - mem_addr = ext_addr, mem_wdata = ext_wdata
  - mem_write = ext_we, mem_read = ~ext_we
- Memory mux otherwise:
  - mem_addr = cpu_addr, mem_wdata = cpu_wdata
  - mem_write = cpu_write, mem_read = cpu_read & ~cpu_write
- cpu_rdata = mem_rdata always. Its value is meaningful only when cpu_read & ~cpu_stall.
- wait_cnt next value:
  - 0 if ~ext_valid or ext_grant
  - else wait_cnt+1, saturating at MAX_WAIT
- Under continuous contention, EXT is granted exactly once every MAX_WAIT+1 cycles. With MAX_WAIT=0, FORCE is permanent.
- Read return: on ext_grant & ~ext_we, the next edge sets ext_rvalid=1 and ext_rdata=mem_rdata. Otherwise ext_rvalid=0 next cycle and ext_rdata holds.
- stall_cnt increments on each edge where cpu_stall=1 and saturates at all-ones.
- When the CPU is stalled it must hold its request unchanged (hazard unit freezes EX/MEM). The arbiter does not latch CPU requests.
- Idle (no requests): mem_read=mem_write=0, mem_addr=cpu_addr.
- Reset (async, any time, including mid-contention): wait_cnt=0, ext_rvalid=0, ext_rdata=0, stall_cnt=0.
  - Combinational outputs follow inputs with wait_cnt=0.
  - A read accepted in the cycle reset asserts never returns rvalid.
- No combinational path from ext_ready to ext_valid is permitted in the EXT master.

Test Plan:
- Reset values: assert rst mid-cycle with ext_valid=1, cpu_read=1 -> ext_rvalid=0, ext_rdata=0, stall_cnt=0 immediately; after release, the first EXT grant comes after 3 blocked cycles (MAX_WAIT=3).
- Idle CPU: ext_valid=1, ext_we=1, ext_addr=0x40, ext_wdata=0xDEADBEEF, cpu idle -> ext_ready=1 same cycle, mem_write=1. Then an EXT read of 0x40 -> ext_rvalid=1 next cycle with ext_rdata=0xDEADBEEF.
- CPU priority: cpu_read=1 at 0x40 with ext_valid=1 held -> cycles 1-3: cpu_stall=0, ext_ready=0, cpu_rdata=0xDEADBEEF; cycle 4: ext_ready=1, cpu_stall=1, stall_cnt 0->1.
- Continuous contention for 12 cycles (MAX_WAIT=3) -> ext_ready high on cycles 4, 8, 12 only; stall_cnt=3.
- Write collision: cpu_write to 0x80 (0x11111111) while a forced EXT write to 0x80 (0x22222222) is granted -> memory holds 0x22222222. CPU retries next cycle unstalled -> 0x11111111 final.
- MAX_WAIT=0 build: ext_valid=1 with cpu_read=1 -> ext_ready=1 and cpu_stall=1 every cycle; wait_cnt stays 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares single-port DataMemory between the CPU memory stage and an external master
// Ports: clk/rst (async active-high); cpu_* memory-stage request, load data and stall;
// ext_* valid/ready request channel with registered read return; mem_* DataMemory drive;
// stall_cnt saturating count of stalled CPU cycles.
module dmem_arbiter #(
  parameter int MAX_WAIT = 3,
  parameter int WAIT_W   = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_read,
  input  logic             cpu_write,
  input  logic [31:0]      cpu_addr,
  input  logic [31:0]      cpu_wdata,
  output logic [31:0]      cpu_rdata,
  output logic             cpu_stall,
  input  logic             ext_valid,
  input  logic             ext_we,
  input  logic [31:0]      ext_addr,
  input  logic [31:0]      ext_wdata,
  output logic             ext_ready,
  output logic             ext_rvalid,
  output logic [31:0]      ext_rdata,
  output logic             mem_read,
  output logic             mem_write,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  output logic [CNT_W-1:0] stall_cnt
);
  logic [WAIT_W-1:0] waitCnt, waitNext;
  logic cpuReq, forceExt, extGrant;
  assign cpuReq    = cpu_read | cpu_write;
  assign forceExt  = waitCnt == WAIT_W'(MAX_WAIT);
  assign extGrant  = ext_valid & (~cpuReq | forceExt);
  assign ext_ready = extGrant;
  assign cpu_stall = cpuReq & extGrant;
  assign cpu_rdata = mem_rdata;
  assign mem_addr  = extGrant ? ext_addr : cpu_addr;
  assign mem_wdata = extGrant ? ext_wdata : cpu_wdata;
  assign mem_write = extGrant ? ext_we : cpu_write;
  // a simultaneous read+write from the CPU is treated as a store
  assign mem_read  = extGrant ? ~ext_we : cpu_read & ~cpu_write;
  // blocked EXT requests age toward a forced grant; any grant or withdrawal restarts the count
  always_comb waitNext = (~ext_valid | extGrant) ? '0 : forceExt ? waitCnt : waitCnt + 1'b1;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      waitCnt    <= '0;
      ext_rvalid <= 1'b0;
      ext_rdata  <= '0;
      stall_cnt  <= '0;
    end else begin
      waitCnt    <= waitNext;
      ext_rvalid <= extGrant & ~ext_we;
      if (extGrant & ~ext_we) ext_rdata <= mem_rdata;
      if (cpu_stall & ~&stall_cnt) stall_cnt <= stall_cnt + 1'b1;
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter (MAX_WAIT=3 main instance, MAX_WAIT=0 second instance)
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic cpu_read, cpu_write, ext_valid, ext_we;
  logic [31:0] cpu_addr, cpu_wdata, ext_addr, ext_wdata, mem_rdata;
  logic [31:0] cpu_rdata, ext_rdata, mem_addr, mem_wdata;
  logic cpu_stall, ext_ready, ext_rvalid, mem_read, mem_write;
  logic [15:0] stall_cnt;
  logic [31:0] d1_cpu_rdata, d1_ext_rdata, d1_mem_addr, d1_mem_wdata;
  logic d1_cpu_stall, d1_ext_ready, d1_ext_rvalid, d1_mem_read, d1_mem_write;
  logic [15:0] d1_stall_cnt;
  logic [31:0] mem [0:255];
  logic [31:0] rdq [$];
  int checks = 0;
  int failures = 0;
  dmem_arbiter #(.MAX_WAIT(3), .WAIT_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .ext_valid(ext_valid),
    .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata), .ext_ready(ext_ready),
    .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .stall_cnt(stall_cnt));
  dmem_arbiter #(.MAX_WAIT(0), .WAIT_W(4), .CNT_W(16)) dut0w (
    .clk(clk), .rst(rst), .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(d1_cpu_rdata), .cpu_stall(d1_cpu_stall), .ext_valid(ext_valid),
    .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata), .ext_ready(d1_ext_ready),
    .ext_rvalid(d1_ext_rvalid), .ext_rdata(d1_ext_rdata), .mem_read(d1_mem_read), .mem_write(d1_mem_write),
    .mem_addr(d1_mem_addr), .mem_wdata(d1_mem_wdata), .mem_rdata(mem_rdata), .stall_cnt(d1_stall_cnt));
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk)
    if (!rst && ext_rvalid === 1'b1) begin
      if (rdq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rvalid_unexpected: got rvalid=1 rdata=0x%08h expected no read pending at %0t", ext_rdata, $time);
      end else chk("ext_rdata", ext_rdata, rdq.pop_front());
    end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    {cpu_read, cpu_write, ext_valid, ext_we} = '0;
    {cpu_addr, cpu_wdata, ext_addr, ext_wdata} = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_rvalid", ext_rvalid, 0);
    chk("rst_rdata", ext_rdata, 0);
    chk("idle_mem_read", mem_read, 0);
    tick;
    ext_valid = 1; ext_we = 1; ext_addr = 32'h40; ext_wdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("idle_ext_ready", ext_ready, 1);
    chk("idle_mem_write", mem_write, 1);
    chk("idle_mem_addr", mem_addr, 32'h40);
    chk("idle_cpu_stall", cpu_stall, 0);
    tick;
    ext_we = 0;
    @(negedge clk);
    chk("ext_rd_ready", ext_ready, 1);
    chk("ext_rd_mem_read", mem_read, 1);
    rdq.push_back(32'hDEADBEEF);
    tick;
    ext_valid = 0;
    @(negedge clk);
    chk("ext_rd_rvalid", ext_rvalid, 1);
    tick;
    cpu_read = 1; cpu_addr = 32'h40; ext_valid = 1; ext_we = 0; ext_addr = 32'h40;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("prio_ext_ready", ext_ready, 32'(i == 4));
      chk("prio_cpu_stall", cpu_stall, 32'(i == 4));
      chk("prio_stall_cnt", stall_cnt, 0);
      if (i < 4) chk("prio_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
      else rdq.push_back(32'hDEADBEEF);
      tick;
    end
    ext_valid = 0;
    @(negedge clk);
    chk("prio_after_stall_cnt", stall_cnt, 1);
    chk("prio_after_cpu_stall", cpu_stall, 0);
    tick;
    ext_valid = 1; ext_we = 1; ext_addr = 32'h100; ext_wdata = 32'hA5A5A5A5;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      chk("cont_ext_ready", ext_ready, 32'(i % 4 == 0));
      chk("cont_cpu_stall", cpu_stall, 32'(i % 4 == 0));
      chk("mw0_ext_ready", d1_ext_ready, 1);
      chk("mw0_cpu_stall", d1_cpu_stall, 1);
      chk("mw0_rvalid", d1_ext_rvalid, 0);
      chk("mw0_mem", {d1_mem_read, d1_mem_write}, 32'b01);
      chk("mw0_mem_wdata", d1_mem_wdata ^ d1_mem_addr ^ d1_cpu_rdata, 32'hA5A5A5A5 ^ 32'h100 ^ mem_rdata);
      tick;
    end
    ext_valid = 0; cpu_read = 0;
    @(negedge clk);
    chk("cont_stall_cnt", stall_cnt, 4);
    chk("mw0_stall_cnt", d1_stall_cnt, 16);
    chk("mw0_ext_rdata", d1_ext_rdata, 32'hDEADBEEF);
    chk("cont_mem_0x100", mem[64], 32'hA5A5A5A5);
    tick;
    cpu_write = 1; cpu_addr = 32'h80; cpu_wdata = 32'h11111111;
    ext_valid = 1; ext_we = 1; ext_addr = 32'h80; ext_wdata = 32'h22222222;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("coll_ext_ready", ext_ready, 32'(i == 4));
      chk("coll_mem_wdata", mem_wdata, i == 4 ? 32'h22222222 : 32'h11111111);
      tick;
      if (i == 4) chk("coll_mem_ext", mem[32], 32'h22222222);
    end
    ext_valid = 0;
    @(negedge clk);
    chk("coll_retry_stall", cpu_stall, 0);
    chk("coll_retry_write", mem_write, 1);
    tick;
    chk("coll_mem_final", mem[32], 32'h11111111);
    cpu_read = 1; cpu_addr = 32'h84;
    @(negedge clk);
    chk("rw_mem_read", mem_read, 0);
    chk("rw_mem_write", mem_write, 1);
    tick;
    cpu_read = 0; cpu_write = 0; cpu_addr = 32'h123;
    @(negedge clk);
    chk("idle_rw", {mem_read, mem_write}, 0);
    chk("idle_addr", mem_addr, 32'h123);
    tick;
    cpu_read = 1; cpu_addr = 32'h40; ext_valid = 1; ext_we = 0; ext_addr = 32'h40;
    repeat (2) begin
      @(negedge clk);
      chk("prerst_ready", ext_ready, 0);
      tick;
    end
    #2 rst = 1'b1;
    #1;
    chk("arst_rvalid", ext_rvalid, 0);
    chk("arst_rdata", ext_rdata, 0);
    chk("arst_stall_cnt", stall_cnt, 0);
    chk("arst_ready", ext_ready, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("postrst_ready", ext_ready, 32'(i == 4));
      if (i == 4) rdq.push_back(32'hDEADBEEF);
      else chk("postrst_rdata", ext_rdata, 0);
      tick;
    end
    ext_valid = 0; cpu_read = 0;
    @(negedge clk);
    chk("postrst_stall_cnt", stall_cnt, 1);
    tick;
    tick;
    chk("rdq_drained", rdq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
